mux_nx1_rr: RTL and testbench
=============================

# mux_nx1_rr

Parametrised, registered N-channel WIDTH-bit multiplexer with valid/ready handshaking. Channels are selected either by round-robin arbitration among requesting inputs or by a fixed select input. It replaces the gate-level 2:1/4:1 selection trees wherever multiple streaming sources share one downstream sink. It provides one output register stage, a fairness pointer and a channel tag on the output.

## Interface
- N_CH, 4, number of input channels (2..16)
- WIDTH, 8, data width per channel (1..64)
- CH_W, $clog2(N_CH), width of channel index (derived, not overridden)

Clock and reset are fixed: one clock `clk`; reset `rst_n` is asynchronous and active-low.

- clk  input  1  rising-edge clock
- rst_n  input  1  asynchronous active-low reset
- in_valid  input  N_CH  per-channel data valid
- in_data  input  N_CH*WIDTH  packed channel data, channel i at bits [i*WIDTH +: WIDTH]
- in_ready  output  N_CH  per-channel accept; at most one bit high per cycle
- mode  input  1  0 = round-robin, 1 = fixed select
- sel  input  CH_W  channel used when mode=1
- out_valid  output  1  output register holds a word
- out_data  output  WIDTH  selected word
- out_ch  output  CH_W  index of the channel the word came from
- out_ready  input  1  sink accepts the word

## Operation
- Output register is free when out_valid=0 or out_ready=1. A grant is issued only when the register is free.
- Round-robin mode (mode=0):
  - Search in_valid starting at pointer `ptr` and wrapping modulo N_CH. The first set bit is the granted channel g.
  - If g is granted, in_ready[g]=1 and ptr <= (g+1) mod N_CH on that edge.
  - If there is no request, ptr is unchanged.
- Fixed mode (mode=1):
  - g = sel, granted only if in_valid[sel]=1. Other channels are never readied.
  - ptr is unchanged in fixed mode.
  - sel >= N_CH means no grant, and all in_ready are 0.
- Transfer on channel g: out_data <= in_data[g], out_ch <= g, out_valid <= 1.
- A consume with no new grant sets out_valid <= 0.
- While out_valid=1 and out_ready=0, out_data and out_ch are held stable and all in_ready are 0.
- in_ready is combinational from in_valid, mode, sel, ptr, out_valid and out_ready. It does not depend on in_data.
- A mode change takes effect in the same cycle. ptr keeps its value across mode changes.

## Timing
- Reset values (asynchronous on rst_n low): out_valid=0, out_data=0, out_ch=0, ptr=0, in_ready=0.
- Latency is 1 cycle, input handshake to out_valid.
- Throughput is 1 word per cycle when out_ready is held high.
- Consume and new grant in the same cycle: out_valid stays 1 and the register is loaded with the new word. There are no bubbles.
- Reset asserted mid-transfer: the pending word is dropped. The first grant after rst_n deassertion starts the search from channel 0.
- rst_n deassertion is synchronised externally. The block does not resynchronise it.

## Structure
- Package `mux_pkg` holds the localparam helpers (CH_W derivation) and the mode encodings MODE_RR=1'b0 and MODE_FIXED=1'b1.
- Sub-module `rr_pick` is purely combinational. Inputs are req[N_CH] and ptr[CH_W]. Outputs are gnt_idx[CH_W] and gnt_any. It is built as a double-width request vector shifted by ptr followed by a priority encoder.
- The top level contains the mode select, the grant gating, ptr, and the output register.

## Test plan
- Reset: hold rst_n=0 with random inputs. Expect out_valid=0, out_ch=0, out_data=0 and in_ready=0. After release with in_valid=4'b1111, the first word has out_ch=0.
- Round-robin fairness: N_CH=4, all channels valid, data channel i = 8'hA0+i, out_ready=1. Expect out_ch sequence 0,1,2,3,0 on consecutive cycles and data A0..A3,A0.
- Sparse wrap: ptr=3 after granting channel 2, in_valid=4'b0101. Expect grant of channel 0, then ptr=1, then grant of channel 2.
- Backpressure: out_ready=0 for 3 cycles with word 8'h55 from channel 1. Expect out_data=55 and out_ch=1 to stay stable, and in_ready=0000. Then out_ready=1 gives consume plus a new grant in the same cycle.
- Fixed mode: mode=1, sel=2, in_valid=4'b1111. Expect only in_ready[2]=1. With sel=2 and in_valid[2]=0, expect no grant and out_valid falling to 0 after consume.
- Mid-stream reset: assert rst_n=0 while out_valid=1 and out_ready=0. Expect out_valid=0 immediately, asynchronously, before the next clock edge.

Source files
------------

// File: rtl/mux_nx1_rr_pkg.sv
// rtl/mux_nx1_rr_pkg.sv - shared mode encodings and width helper for mux_nx1_rr
package mux_pkg;

  localparam logic MODE_RR    = 1'b0;
  localparam logic MODE_FIXED = 1'b1;

  // A 2-channel mux still needs a 1-bit index, so never return 0.
  function automatic int ch_w(input int n);
    return (n > 2) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/mux_nx1_rr_if.sv
// rtl/mux_nx1_rr_if.sv - input-channel and output-sink handshake bundle for mux_nx1_rr
interface mux_nx1_rr_if
  import mux_pkg::*;
#(
  parameter int N_CH  = 4,
  parameter int WIDTH = 8
) ();

  localparam int CH_W = ch_w(N_CH);

  logic [N_CH-1:0]       in_valid;
  logic [N_CH*WIDTH-1:0] in_data;
  logic [N_CH-1:0]       in_ready;
  logic                  out_valid;
  logic [WIDTH-1:0]      out_data;
  logic [CH_W-1:0]       out_ch;
  logic                  out_ready;

  modport slave (
    input  in_valid, in_data, out_ready,
    output in_ready, out_valid, out_data, out_ch
  );

  modport master (
    output in_valid, in_data, out_ready,
    input  in_ready, out_valid, out_data, out_ch
  );

endinterface

// File: rtl/mux_nx1_rr_pick.sv
// rtl/mux_nx1_rr_pick.sv - combinational round-robin picker: rotate requests by ptr, take lowest set bit
module rr_pick
  import mux_pkg::*;
#(
  parameter  int N_CH = 4,
  localparam int CH_W = ch_w(N_CH)
) (
  input  logic [N_CH-1:0] req,
  input  logic [CH_W-1:0] ptr,
  output logic [CH_W-1:0] gnt_idx,
  output logic            gnt_any
);

  logic [2*N_CH-1:0] req2;
  logic [N_CH-1:0]   rot;
  logic [CH_W:0]     sum;

  always_comb begin
    req2    = {req, req};
    rot     = N_CH'(req2 >> ptr);
    gnt_any = |rot;
    sum     = '0;
    // Descending scan so the lowest rotated bit (closest to ptr) wins.
    for (int i = N_CH - 1; i >= 0; i--) begin
      if (rot[i]) begin
        sum = {1'b0, ptr} + (CH_W + 1)'(i);
      end
    end
    if (sum >= (CH_W + 1)'(N_CH)) begin
      sum = sum - (CH_W + 1)'(N_CH);
    end
    gnt_idx = sum[CH_W-1:0];
  end

endmodule

// File: rtl/mux_nx1_rr.sv
// rtl/mux_nx1_rr.sv - registered N:1 stream mux with round-robin or fixed channel select
module mux_nx1_rr
  import mux_pkg::*;
#(
  parameter  int N_CH  = 4,
  parameter  int WIDTH = 8,
  localparam int CH_W  = ch_w(N_CH)
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            mode,
  input  logic [CH_W-1:0] sel,
  mux_nx1_rr_if.slave     bus
);

  logic [CH_W-1:0]  ptr_q, ptr_d;
  logic [CH_W-1:0]  ch_q, ch_d;
  logic             valid_q, valid_d;
  logic [WIDTH-1:0] data_q, data_d;

  logic [CH_W-1:0]  pick_idx, gnt_idx;
  logic             pick_any, gnt_any, fixed_ok, reg_free, grant;
  logic [WIDTH-1:0] gnt_data;

  rr_pick #(.N_CH(N_CH)) u_pick (
    .req     (bus.in_valid),
    .ptr     (ptr_q),
    .gnt_idx (pick_idx),
    .gnt_any (pick_any)
  );

  always_comb begin
    fixed_ok = 1'b0;
    gnt_data = '0;
    reg_free = !valid_q || bus.out_ready;
    // Loop compare keeps an out-of-range sel from ever indexing in_valid.
    for (int i = 0; i < N_CH; i++) begin
      if (sel == CH_W'(i)) fixed_ok = bus.in_valid[i];
    end
    if (mode == MODE_FIXED) begin
      gnt_idx = sel;
      gnt_any = fixed_ok;
    end else begin
      gnt_idx = pick_idx;
      gnt_any = pick_any;
    end
    grant = rst_n && reg_free && gnt_any;
    for (int i = 0; i < N_CH; i++) begin
      bus.in_ready[i] = grant && (gnt_idx == CH_W'(i));
      if (gnt_idx == CH_W'(i)) gnt_data = bus.in_data[i*WIDTH +: WIDTH];
    end
  end

  always_comb begin
    ptr_d   = ptr_q;
    valid_d = valid_q;
    data_d  = data_q;
    ch_d    = ch_q;
    if (grant) begin
      valid_d = 1'b1;
      data_d  = gnt_data;
      ch_d    = gnt_idx;
      if (mode == MODE_RR) begin
        ptr_d = (gnt_idx == CH_W'(N_CH - 1)) ? '0 : gnt_idx + 1'b1;
      end
    end else if (bus.out_ready) begin
      valid_d = 1'b0;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ptr_q   <= '0;
      ch_q    <= '0;
      valid_q <= 1'b0;
      data_q  <= '0;
    end else begin
      ptr_q   <= ptr_d;
      ch_q    <= ch_d;
      valid_q <= valid_d;
      data_q  <= data_d;
    end
  end

  assign bus.out_valid = valid_q;
  assign bus.out_data  = data_q;
  assign bus.out_ch    = ch_q;

endmodule

// File: tb/tb_mux_nx1_rr.sv
// tb/tb_mux_nx1_rr.sv - scoreboard bench for mux_nx1_rr with a queue-based arbitration model
module tb_mux_nx1_rr;
  import mux_pkg::*;

  localparam int N = 4;
  localparam int W = 8;

  typedef struct {
    int           ch;
    logic [W-1:0] data;
  } exp_t;

  logic       clk   = 1'b0;
  logic       rst_n = 1'b0;
  logic       mode  = 1'b0;
  logic [1:0] sel   = '0;

  int   n_vec  = 0;
  int   n_err  = 0;
  int   ptr_m  = 0;
  bit   full_m = 1'b0;
  logic [W-1:0] dat [N];
  exp_t sb [$];

  always #5 clk = ~clk;

  mux_nx1_rr_if #(.N_CH(N), .WIDTH(W)) bus ();

  mux_nx1_rr #(.N_CH(N), .WIDTH(W)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .mode  (mode),
    .sel   (sel),
    .bus   (bus)
  );

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // One cycle: apply inputs, predict the grant from the spec rules, push the granted word.
  task automatic drive(input logic [N-1:0] v, input logic m, input logic [1:0] s, input logic r);
    int g;
    logic [N-1:0] er;
    bus.in_valid  = v;
    mode          = m;
    sel           = s;
    bus.out_ready = r;
    for (int k = 0; k < N; k++) bus.in_data[k*W +: W] = dat[k];
    @(negedge clk);
    g  = -1;
    er = '0;
    if (!full_m || r) begin
      if (m == MODE_RR) begin
        for (int k = 0; k < N; k++) begin
          if (g < 0 && v[(ptr_m + k) % N]) g = (ptr_m + k) % N;
        end
      end else if (v[s]) begin
        g = int'(s);
      end
    end
    if (g >= 0) er[g] = 1'b1;
    check("in_ready", 64'(bus.in_ready), 64'(er));
    check("out_valid", 64'(bus.out_valid), 64'(full_m));
    if (g >= 0) begin
      sb.push_back('{g, dat[g]});
      full_m = 1'b1;
      if (m == MODE_RR) ptr_m = (g + 1) % N;
    end else if (r) begin
      full_m = 1'b0;
    end
    @(posedge clk);
    #1;
  endtask

  always @(negedge clk) begin
    if (rst_n && bus.out_valid) begin
      if (sb.size() == 0) begin
        n_vec++;
        n_err++;
        $display("FAIL unexpected_word: got ch %0d data %0h expected no word", bus.out_ch, bus.out_data);
      end else begin
        check("out_ch", 64'(bus.out_ch), 64'(sb[0].ch));
        check("out_data", 64'(bus.out_data), 64'(sb[0].data));
        if (bus.out_ready) void'(sb.pop_front());
      end
    end
  end

  initial begin
    bus.in_valid  = '0;
    bus.in_data   = '0;
    bus.out_ready = 1'b0;
    for (int k = 0; k < N; k++) dat[k] = '0;

    for (int t = 0; t < 3; t++) begin
      bus.in_valid  = N'($urandom);
      bus.in_data   = (N*W)'($urandom);
      bus.out_ready = 1'($urandom);
      mode          = 1'($urandom);
      sel           = 2'($urandom);
      @(negedge clk);
      check("rst_out_valid", 64'(bus.out_valid), 64'd0);
      check("rst_out_ch", 64'(bus.out_ch), 64'd0);
      check("rst_out_data", 64'(bus.out_data), 64'd0);
      check("rst_in_ready", 64'(bus.in_ready), 64'd0);
    end
    @(posedge clk);
    #3 rst_n = 1'b1;

    for (int k = 0; k < N; k++) dat[k] = 8'hA0 + 8'(k);
    repeat (5) drive(4'b1111, MODE_RR, 2'd0, 1'b1);

    drive(4'b0100, MODE_RR, 2'd0, 1'b1);
    drive(4'b0101, MODE_RR, 2'd0, 1'b1);
    drive(4'b0101, MODE_RR, 2'd0, 1'b1);

    dat[1] = 8'h55;
    drive(4'b0010, MODE_RR, 2'd0, 1'b1);
    repeat (3) drive(4'b1111, MODE_RR, 2'd0, 1'b0);
    drive(4'b1111, MODE_RR, 2'd0, 1'b1);

    repeat (3) drive(4'b1111, MODE_FIXED, 2'd2, 1'b1);
    drive(4'b1011, MODE_FIXED, 2'd2, 1'b1);
    drive(4'b0000, MODE_FIXED, 2'd2, 1'b1);

    drive(4'b1111, MODE_RR, 2'd0, 1'b1);
    drive(4'b0000, MODE_RR, 2'd0, 1'b0);
    #1 rst_n = 1'b0;
    #1;
    check("async_rst_out_valid", 64'(bus.out_valid), 64'd0);
    check("async_rst_out_data", 64'(bus.out_data), 64'd0);
    check("async_rst_out_ch", 64'(bus.out_ch), 64'd0);
    sb.delete();
    full_m = 1'b0;
    ptr_m  = 0;
    @(posedge clk);
    #3 rst_n = 1'b1;
    drive(4'b1111, MODE_RR, 2'd0, 1'b1);

    repeat (3000) begin
      for (int k = 0; k < N; k++) dat[k] = W'($urandom);
      drive(N'($urandom), ($urandom_range(0, 3) == 0), 2'($urandom), ($urandom_range(0, 3) != 0));
    end

    drive(4'b0000, MODE_RR, 2'd0, 1'b1);
    drive(4'b0000, MODE_RR, 2'd0, 1'b1);
    check("sb_drained", 64'(sb.size()), 64'd0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
